// File: rtl/instr_encode_loader_pkg.sv
// Shared RV32I encoding constants, mnemonic enum and immediate range helper
// for instr_encode_loader and its instr_encoder sub-module.
package instr_encode_loader_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_JAL  = 4'd9,
    OP_JALR = 4'd10,
    OP_LUI  = 4'd11
  } instr_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111
  } op_code_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM_B_MIN = -4096;
  localparam int signed IMM_B_MAX = 4094;
  localparam int signed IMM_J_MIN = -(1 << 20);
  localparam int signed IMM_J_MAX = (1 << 20) - 2;

  function automatic logic imm_ok(input logic signed [31:0] v,
                                  input int signed lo,
                                  input int signed hi,
                                  input logic need_even);
    return (v >= lo) && (v <= hi) && !(need_even && v[0]);
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational RV32I encoder: mnemonic, registers and immediate to a
// 32-bit word; illegal immediates or ops yield NOP with imm_err set.
module instr_encoder
  import instr_encode_loader_pkg::*;
(
  input  instr_op_e          op,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic signed [31:0] imm,
  output logic [31:0]        word,
  output logic               imm_err
);

  always_comb begin
    word    = NOP_WORD;
    imm_err = 1'b0;
    case (op)
      OP_ADD: word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      OP_SUB: word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      OP_AND: word = {F7_BASE, rs2, rs1, F3_AND,     rd, OPC_OP};
      OP_OR:  word = {F7_BASE, rs2, rs1, F3_OR,      rd, OPC_OP};
      OP_XOR: word = {F7_BASE, rs2, rs1, F3_XOR,     rd, OPC_OP};
      OP_ADDI, OP_LW, OP_JALR: begin
        if (imm_ok(imm, IMM12_MIN, IMM12_MAX, 1'b0)) begin
          if (op == OP_ADDI)    word = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM};
          else if (op == OP_LW) word = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
          else                  word = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
        end else begin
          imm_err = 1'b1;
        end
      end
      OP_SW: begin
        if (imm_ok(imm, IMM12_MIN, IMM12_MAX, 1'b0))
          word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
        else
          imm_err = 1'b1;
      end
      // Branch and jump offsets are in bytes; bit 0 is implied zero.
      OP_BEQ: begin
        if (imm_ok(imm, IMM_B_MIN, IMM_B_MAX, 1'b1))
          word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
        else
          imm_err = 1'b1;
      end
      OP_JAL: begin
        if (imm_ok(imm, IMM_J_MIN, IMM_J_MAX, 1'b1))
          word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        else
          imm_err = 1'b1;
      end
      OP_LUI: word = {imm[31:12], rd, OPC_LUI};
      default: imm_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// RV32I encoder with in-order program buffer and registered byte-PC fetch port.
// Optional INSTR_CHECKSUM_EN adds an XOR checksum of all stored words.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [3:0]        enc_op,
  input  logic [4:0]        enc_rd,
  input  logic [4:0]        enc_rs1,
  input  logic [4:0]        enc_rs2,
  input  logic [31:0]       enc_imm,
  input  logic              fetch_en,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              fetch_valid,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err_imm
`ifdef INSTR_CHECKSUM_EN
  ,output logic [31:0]      checksum
`endif
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       enc_word;
  logic              enc_err;
  logic              accept;
  logic [ADDR_W-1:0] fetch_idx;
  logic              fetch_hit;
  logic              unused_addr_lsb;

  instr_encoder u_encoder (
    .op      (instr_op_e'(enc_op)),
    .rd      (enc_rd),
    .rs1     (enc_rs1),
    .rs2     (enc_rs2),
    .imm     (enc_imm),
    .word    (enc_word),
    .imm_err (enc_err)
  );

  assign full      = (word_count == DEPTH_CNT);
  assign enc_ready = !full && !clear;
  assign accept    = enc_valid && enc_ready;

  // Encode stage boundary: word lands in memory on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count <= '0;
      wr_ptr     <= '0;
      err_imm    <= 1'b0;
    end else if (clear) begin
      word_count <= '0;
      wr_ptr     <= '0;
      err_imm    <= 1'b0;
    end else if (accept) begin
      word_count <= word_count + (ADDR_W+1)'(1);
      wr_ptr     <= wr_ptr + ADDR_W'(1);
      err_imm    <= err_imm | enc_err;
    end
  end

`ifdef INSTR_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    checksum <= '0;
    else if (clear)  checksum <= '0;
    else if (accept) checksum <= checksum ^ enc_word;
  end
`endif

  // Word index ignores byte offset; anything past the buffer or past the
  // stored program (pre-edge count) reads back as NOP.
  assign fetch_idx       = fetch_addr[ADDR_W+1:2];
  assign fetch_hit       = ((fetch_addr >> (ADDR_W + 2)) == 32'd0) &&
                           ({1'b0, fetch_idx} < word_count);
  assign unused_addr_lsb = ^fetch_addr[1:0];

  // Fetch stage boundary: one-cycle registered read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_instr <= '0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= fetch_en;
      if (fetch_en) fetch_instr <= fetch_hit ? mem[fetch_idx] : NOP_WORD;
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader (DEPTH=4): directed cases plus
// randomized requests against a field-arithmetic reference model.
module tb_instr_encode_loader;
  import instr_encode_loader_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        enc_valid;
  logic        enc_ready;
  logic [3:0]  enc_op;
  logic [4:0]  enc_rd, enc_rs1, enc_rs2;
  logic [31:0] enc_imm;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_valid;
  logic [AW:0] word_count;
  logic        full;
  logic        err_imm;
`ifdef INSTR_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instr_encode_loader #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .enc_valid   (enc_valid),
    .enc_ready   (enc_ready),
    .enc_op      (enc_op),
    .enc_rd      (enc_rd),
    .enc_rs1     (enc_rs1),
    .enc_rs2     (enc_rs2),
    .enc_imm     (enc_imm),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .fetch_valid (fetch_valid),
    .word_count  (word_count),
    .full        (full),
    .err_imm     (err_imm)
`ifdef INSTR_CHECKSUM_EN
    ,.checksum   (checksum)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  int          m_count;
  bit          m_err;
  logic [31:0] m_csum;
  logic [31:0] m_fetch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Encoding from the ISA field layout using plain integer arithmetic.
  function automatic logic [31:0] ref_encode(input int op, input int rd, input int rs1,
                                             input int rs2, input int imm, output bit bad);
    int w;
    int f3;
    bad = 0;
    w   = 32'h13;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        f3 = (op == OP_AND) ? 7 : (op == OP_OR) ? 6 : (op == OP_XOR) ? 4 : 0;
        w = ((op == OP_SUB) ? 32 : 0) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
            + f3 * (1 << 12) + rd * (1 << 7) + 51;
      end
      OP_ADDI, OP_LW, OP_JALR: begin
        if (imm < -2048 || imm > 2047) bad = 1;
        else w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (((op == OP_LW) ? 2 : 0) << 12)
                 | (rd << 7) | ((op == OP_ADDI) ? 19 : (op == OP_LW) ? 3 : 103);
      end
      OP_SW: begin
        if (imm < -2048 || imm > 2047) bad = 1;
        else w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                 | ((imm & 31) << 7) | 35;
      end
      OP_BEQ: begin
        if (imm < -4096 || imm > 4094 || (imm % 2) != 0) bad = 1;
        else w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
                 | (rs1 << 15) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 99;
      end
      OP_JAL: begin
        if (imm < -(1 << 20) || imm > (1 << 20) - 2 || (imm % 2) != 0) bad = 1;
        else w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                 | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | 111;
      end
      OP_LUI: w = (imm & 32'hFFFF_F000) | (rd << 7) | 55;
      default: bad = 1;
    endcase
    return 32'(w);
  endfunction

  task automatic check_status(input string tag);
    chk({tag, ".word_count"}, 32'(word_count), 32'(m_count));
    chk({tag, ".full"}, 32'(full), 32'(m_count == DEPTH));
    chk({tag, ".err_imm"}, 32'(err_imm), 32'(m_err));
`ifdef INSTR_CHECKSUM_EN
    chk({tag, ".checksum"}, checksum, m_csum);
`endif
  endtask

  task automatic req(input string tag, input int op, input int rd, input int rs1,
                     input int rs2, input int imm, input bit do_clear);
    bit exp_rdy;
    bit bad;
    logic [31:0] w;
    @(negedge clk);
    enc_valid = 1'b1;
    enc_op    = 4'(op);
    enc_rd    = 5'(rd);
    enc_rs1   = 5'(rs1);
    enc_rs2   = 5'(rs2);
    enc_imm   = imm;
    clear     = do_clear;
    #1;
    exp_rdy = (m_count < DEPTH) && !do_clear;
    chk({tag, ".enc_ready"}, 32'(enc_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (do_clear) begin
      m_count = 0;
      m_err   = 0;
      m_csum  = '0;
    end else if (exp_rdy) begin
      w = ref_encode(op, rd, rs1, rs2, imm, bad);
      m_mem[m_count] = w;
      m_count++;
      m_err  = m_err | bad;
      m_csum = m_csum ^ w;
    end
    enc_valid = 1'b0;
    clear     = 1'b0;
    check_status(tag);
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr);
    logic [31:0] exp;
    @(negedge clk);
    fetch_en   = 1'b1;
    fetch_addr = addr;
    @(posedge clk);
    #1;
    if (addr >= 32'(DEPTH * 4) || int'(addr >> 2) >= m_count) exp = NOP;
    else exp = m_mem[addr >> 2];
    m_fetch = exp;
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'd1);
    chk({tag, ".fetch_instr"}, fetch_instr, exp);
    fetch_en = 1'b0;
  endtask

  task automatic fetch_idle(input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, ".fetch_hold"}, fetch_instr, m_fetch);
  endtask

  function automatic int rand_imm();
    int table_v [12] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, -4098,
                         (1 << 20) - 2, -(1 << 20), (1 << 20), 3};
    case ($urandom_range(0, 4))
      0: return int'($urandom_range(0, 4095)) - 2048;
      1: return table_v[$urandom_range(0, 11)];
      2: return int'($urandom);
      3: return 2 * (int'($urandom_range(0, 128)) - 64);
      default: return 2 * (int'($urandom_range(0, 1 << 20)) - (1 << 19));
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; clear = 1'b0; enc_valid = 1'b0; enc_op = '0;
    enc_rd = '0; enc_rs1 = '0; enc_rs2 = '0; enc_imm = '0;
    fetch_en = 1'b0; fetch_addr = '0;
    m_count = 0; m_err = 0; m_csum = '0; m_fetch = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    #12;
    check_status("reset");
    chk("reset.fetch_valid", 32'(fetch_valid), 32'd0);
    chk("reset.fetch_instr", fetch_instr, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_reset.enc_ready", 32'(enc_ready), 32'd1);

    // Known encodings
    req("add", OP_ADD, 3, 1, 2, 0, 0);
    fetch("add_f", 32'h0);
    chk("add_const", fetch_instr, 32'h002081B3);
    req("sub", OP_SUB, 5, 6, 7, 0, 0);
    req("addi", OP_ADDI, 1, 0, 0, -1, 0);
    fetch("sub_f", 32'h4);
    chk("sub_const", fetch_instr, 32'h407302B3);
    fetch("addi_f", 32'h8);
    chk("addi_const", fetch_instr, 32'hFFF00093);
    fetch_idle("idle1");
    req("beq", OP_BEQ, 0, 1, 2, 8, 0);
    fetch("beq_f", 32'hF);
    chk("beq_const", fetch_instr, 32'h00208463);

    // Full buffer stalls; beyond-buffer fetch gives NOP
    req("stall", OP_JAL, 1, 0, 0, 2048, 0);
    fetch("oob_f", 32'h10);
    chk("oob_const", fetch_instr, NOP);

    // Clear beats a simultaneous request
    req("clear", OP_ADD, 1, 1, 1, 0, 1);
    req("jal", OP_JAL, 1, 0, 0, 2048, 0);
    fetch("jal_f", 32'h0);
    chk("jal_const", fetch_instr, 32'h001000EF);

    // Immediate errors store NOP and still advance
    req("addi_big", OP_ADDI, 1, 1, 0, 4096, 0);
    chk("addi_big.err", 32'(err_imm), 32'd1);
    req("beq_odd", OP_BEQ, 0, 1, 2, 3, 0);
    fetch("addi_big_f", 32'h4);
    chk("addi_big_nop", fetch_instr, NOP);
    fetch("beq_odd_f", 32'h8);
    fetch("past_count_f", 32'hC);

    // Async reset mid-request
    @(negedge clk);
    enc_valid = 1'b1; enc_op = 4'(OP_ADD); enc_rd = 5'd9;
    #2;
    reset_n = 1'b0;
    #1;
    m_count = 0; m_err = 0; m_csum = '0; m_fetch = '0;
    check_status("areset");
    chk("areset.fetch_valid", 32'(fetch_valid), 32'd0);
    chk("areset.fetch_instr", fetch_instr, 32'd0);
    @(posedge clk);
    #1;
    chk("areset_hold.word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    enc_valid = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      if (m_count == DEPTH && $urandom_range(0, 1) == 0)
        req("rnd_clear", OP_ADD, 0, 0, 0, 0, 1);
      else
        req("rnd_req", int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rand_imm(),
            $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1)
        fetch("rnd_fetch", 32'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Hardware RISC-V RV32I instruction encoder with a program buffer. It takes operation requests (mnemonic, rd, rs1, rs2, immediate) over a valid/ready handshake, encodes each one to its 32-bit binary word, and writes the words in order into an internal instruction memory of parameterised depth. A registered fetch port lets the CPU fetch stage or testbench read the stored program by byte PC.

Parameters:
DEPTH, 32, number of 32-bit instruction words stored (power of two, >=2)
ADDR_W, $clog2(DEPTH), word index width (derived)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous program clear
enc_valid  input  1  encode request valid
enc_ready  output  1  encoder can accept
enc_op  input  4  instr_op_e mnemonic
enc_rd  input  5  destination register
enc_rs1  input  5  source register 1
enc_rs2  input  5  source register 2
enc_imm  input  32  signed immediate / byte offset; LUI uses imm[31:12]
fetch_en  input  1  fetch read strobe
fetch_addr  input  32  byte PC
fetch_instr  output  32  fetched word
fetch_valid  output  1  fetch_instr valid
word_count  output  ADDR_W+1  words stored
full  output  1  word_count == DEPTH
err_imm  output  1  sticky immediate-range error

Behaviour:
- Reset (async, reset_n low): word_count=0, write pointer=0, full=0, err_imm=0, fetch_instr=0, fetch_valid=0. enc_ready goes to 1 after reset is released.
- enc_ready = !full && !clear (combinational).
- Accept on enc_valid && enc_ready.
  - The encoded word is written to mem[wr_ptr] in the same edge.
  - wr_ptr and word_count increment at that edge.
  - The word is fetchable from the next cycle.
- Supported ops:
  - ADD, SUB, AND, OR, XOR: R-type, opcode 0110011.
  - ADDI: I-type, 0010011, funct3 000.
  - LW: 0000011, funct3 010.
  - SW: S-type, 0100011, funct3 010.
  - BEQ: B-type, 1100011, funct3 000.
  - JAL: J-type, 1101111.
  - JALR: 1100111, funct3 000.
  - LUI: U-type, 0110111.
- Immediate range checks:
  - I-type and S-type: -2048..2047.
  - BEQ: -4096..4094, even.
  - JAL: -2^20..2^20-2, even.
  - LUI: unchecked.
- Out-of-range or misaligned immediate, or an undefined enc_op code: the NOP 0x00000013 is stored instead, err_imm is set, and the handshake still completes.
- Full: once word_count==DEPTH, enc_ready=0 and further requests stall. The write pointer never wraps.
- clear (synchronous): word_count, wr_ptr and err_imm go to 0 next edge. Memory contents are not zeroed. If clear and a request occur in the same cycle, clear wins and the request is not accepted (enc_ready=0).
- Fetch: index = fetch_addr[ADDR_W+1:2]. fetch_addr[1:0] is ignored.
  - Latency 1. On a fetch_en edge, fetch_instr = mem[index] if index < word_count, else NOP. fetch_valid=1 that following cycle.
  - If fetch_en is low, fetch_valid=0 and fetch_instr holds its value.
  - fetch_addr at or beyond DEPTH*4 returns NOP.
- A fetch of the index being written in the same cycle returns the NOP, because the old word_count is used.
- reset_n asserted mid-stream: all state is cleared immediately and any in-flight handshake is discarded.

Optional Feature:
- Macro INSTR_CHECKSUM_EN.
- When defined: adds output checksum[31:0], reset 0, cleared by clear. It is XOR-accumulated with every stored word (including NOP substitutions) at each accept edge.
- When undefined: the port and logic are absent.

Decomposition:
- Shared package: instr_op_e enum, op_code_e opcode constants, funct3/funct7 constants, the NOP constant, and the immediate min/max constants.
- One sub-module, instr_encoder: purely combinational. Inputs are op, regs and imm; outputs are the word and an imm_err flag.
- The top level owns the handshake, the memory, the counters and the fetch port.

Test Plan:
- ADD rd=3 rs1=1 rs2=2 -> mem[0]=0x002081B3; fetch_addr=0 gives fetch_instr=0x002081B3 one cycle later.
- SUB 5,6,7 and ADDI rd=1 rs1=0 imm=-1 -> 0x407302B3 and 0xFFF00093 at fetch_addr 0x4 and 0x8.
- BEQ rs1=1 rs2=2 imm=8 -> 0x00208463; JAL rd=1 imm=2048 -> 0x001000EF.
- ADDI imm=4096, then BEQ imm=3 -> both stored as 0x00000013; err_imm=1 after the first; word_count advances by 2.
- DEPTH=4, five back-to-back requests -> four accepted; full=1 and enc_ready=0 on the fifth; fetch_addr=0x10 returns NOP.
- clear asserted together with enc_valid -> request not accepted; word_count=0 and err_imm=0 next cycle. With INSTR_CHECKSUM_EN, checksum=0. Async reset mid-burst zeroes all outputs.
